// File: rtl/tx_redundancy_buffer.sv
// Segment replay buffer for redundant Ethernet transmission: the first copy of a
// segment is captured while streamed out, later copies are replayed from RAM.
module tx_redundancy_buffer #(
  parameter int DATA_W        = 8,
  parameter int PAYLOAD_BYTES = 1440,
  parameter int SEGMENTS      = 150,
  parameter int ADDR_W        = 24
) (
  input  logic              clk125MHz,
  input  logic              rst_n,
  input  logic [7:0]        txid,
  input  logic [7:0]        redundancy,
  input  logic [15:0]       segment_num,
  input  logic              frame_start,
  input  logic              byte_req,
  input  logic [DATA_W-1:0] src_data,
  input  logic [ADDR_W-1:0] src_addr,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [ADDR_W-1:0] startaddr,
  output logic              replay_miss,
  output logic              bad_id,
  output logic              busy
);

  localparam int DEPTH  = SEGMENTS * PAYLOAD_BYTES;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SEG_W  = (SEGMENTS > 1) ? $clog2(SEGMENTS) : 1;
  localparam int CNT_W  = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PAYLOAD_BYTES - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, REPLAY} state_t;

  state_t              state, fs_mode, eff_mode, nxt_state;
  logic [CNT_W-1:0]    cnt, eff_cnt, nxt_cnt;
  logic [15:0]         seg_q, eff_seg;
  logic                eff_miss, fs_miss, fs_bad, fs_in_range;
  logic                accept, last_word;
  logic [SEG_W-1:0]    seg_in_idx, eff_idx;
  logic [MEM_AW-1:0]   addr;
  logic [SEGMENTS-1:0] slot_valid;
  logic [ADDR_W-1:0]   start_tab [SEGMENTS];
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   ram_q, fwd_q;
  logic                v1, sel_fwd1, miss1;

  // A frame_start overrides the running frame in the same cycle, so every
  // decision below is taken on the "effective" frame context.
  always_comb begin
    fs_in_range = int'(segment_num) < SEGMENTS;
    seg_in_idx  = SEG_W'(segment_num);
    fs_bad      = (txid == 8'd0) || (txid > redundancy);
    fs_mode     = IDLE;
    fs_miss     = 1'b0;
    if (!fs_bad) begin
      if (txid == 8'd1) begin
        fs_mode = CAPTURE;
        fs_miss = !fs_in_range;
      end else begin
        fs_mode = REPLAY;
        fs_miss = !fs_in_range || !slot_valid[seg_in_idx];
      end
    end
    if (frame_start) begin
      eff_mode = fs_mode;
      eff_cnt  = '0;
      eff_seg  = segment_num;
      eff_miss = fs_miss;
    end else begin
      eff_mode = state;
      eff_cnt  = cnt;
      eff_seg  = seg_q;
      eff_miss = replay_miss;
    end
    eff_idx   = SEG_W'(eff_seg);
    accept    = byte_req && (eff_mode != IDLE);
    last_word = (eff_cnt == LAST);
    addr      = MEM_AW'(int'(eff_seg) * PAYLOAD_BYTES + int'(eff_cnt));
    nxt_state = eff_mode;
    nxt_cnt   = eff_cnt;
    if (accept) begin
      if (last_word) begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end else begin
        nxt_cnt = eff_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk125MHz) begin
    if (accept && eff_mode == CAPTURE && !eff_miss) mem[addr] <= src_data;
    ram_q <= mem[addr];
  end

  always_ff @(posedge clk125MHz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      cnt         <= '0;
      seg_q       <= '0;
      replay_miss <= 1'b0;
      bad_id      <= 1'b0;
      startaddr   <= '0;
      slot_valid  <= '0;
      for (int unsigned i = 0; i < SEGMENTS; i++) start_tab[i] <= '0;
      v1          <= 1'b0;
      sel_fwd1    <= 1'b0;
      miss1       <= 1'b0;
      fwd_q       <= '0;
      dout        <= '0;
      dout_valid  <= 1'b0;
    end else begin
      state  <= nxt_state;
      busy   <= (nxt_state != IDLE);
      cnt    <= nxt_cnt;
      bad_id <= frame_start && fs_bad;
      if (frame_start) begin
        seg_q       <= segment_num;
        replay_miss <= fs_miss;
        if (fs_mode == CAPTURE) begin
          startaddr <= src_addr;
          if (fs_in_range) begin
            slot_valid[seg_in_idx] <= 1'b0;
            start_tab[seg_in_idx]  <= src_addr;
          end
        end else if (fs_mode == REPLAY) begin
          startaddr <= fs_in_range ? start_tab[seg_in_idx] : '0;
        end
      end
      // Placed after the clear so a completing one-word capture still validates.
      if (accept && last_word && eff_mode == CAPTURE && !eff_miss)
        slot_valid[eff_idx] <= 1'b1;
      v1         <= accept;
      sel_fwd1   <= (eff_mode == CAPTURE);
      miss1      <= eff_miss && (eff_mode == REPLAY);
      fwd_q      <= src_data;
      dout_valid <= v1;
      if (!v1 || miss1) dout <= '0;
      else              dout <= sel_fwd1 ? fwd_q : ram_q;
    end
  end

endmodule

// File: tb/tb_tx_redundancy_buffer.sv
// Randomised bench for tx_redundancy_buffer against a per-segment array model.
module tb_tx_redundancy_buffer;

  localparam int PB = 4;
  localparam int NS = 2;

  logic        clk125MHz = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  txid = '0, redundancy = 8'd3;
  logic [15:0] segment_num = '0;
  logic        frame_start = 1'b0, byte_req = 1'b0;
  logic [7:0]  src_data = '0;
  logic [23:0] src_addr = '0;
  logic [7:0]  dout;
  logic        dout_valid;
  logic [23:0] startaddr;
  logic        replay_miss, bad_id, busy;

  tx_redundancy_buffer #(.DATA_W(8), .PAYLOAD_BYTES(PB), .SEGMENTS(NS), .ADDR_W(24)) dut (
    .clk125MHz(clk125MHz), .rst_n(rst_n), .txid(txid), .redundancy(redundancy),
    .segment_num(segment_num), .frame_start(frame_start), .byte_req(byte_req),
    .src_data(src_data), .src_addr(src_addr), .dout(dout), .dout_valid(dout_valid),
    .startaddr(startaddr), .replay_miss(replay_miss), .bad_id(bad_id), .busy(busy)
  );

  always #4 clk125MHz = ~clk125MHz;

  int cyc = 0;
  always @(posedge clk125MHz) cyc++;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct { int c; logic [7:0] d; } exp_t;
  exp_t q[$];

  // Model of buffer contents and the frame in progress
  bit          m_valid [NS];
  logic [7:0]  m_mem [NS][PB];
  logic [23:0] m_start [NS];
  bit          m_start_known [NS];
  bit          m_active, m_cap, m_miss, exp_bad, exp_sa_known;
  int          m_seg, m_idx;
  logic [23:0] exp_sa;
  bit          mon_en = 1'b0;

  always @(negedge clk125MHz) begin
    if (mon_en) begin
      n_checks++;
      if (q.size() > 0 && q[0].c <= cyc) begin
        if (dout_valid !== 1'b1 || dout !== q[0].d || q[0].c != cyc) begin
          n_fail++;
          $display("FAIL dout cyc=%0d: got valid=%b data=%h, expected valid=1 data=%h (due cyc %0d)",
                   cyc, dout_valid, dout, q[0].d, q[0].c);
        end
        void'(q.pop_front());
      end else if (dout_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL dout_valid_idle cyc=%0d: got valid=%b data=%h, expected valid=0", cyc, dout_valid, dout);
      end
    end
  end

  task automatic tick();
    @(posedge clk125MHz);
    #1;
  endtask

  task automatic step(input bit fs, input logic [7:0] id, input int seg, input logic [23:0] addr,
                      input bit req, input logic [7:0] d);
    logic [7:0] exp_d;
    frame_start = fs;
    byte_req    = req;
    src_data    = d;
    if (fs) begin
      txid = id; segment_num = 16'(seg); src_addr = addr;
    end else begin
      txid = 8'($urandom_range(0, 255)); segment_num = 16'($urandom_range(0, 65535));
      src_addr = 24'($urandom);
    end
    exp_bad = 1'b0;
    if (fs) begin
      m_active = 1'b0;
      if (id == 8'd0 || id > 8'd3) exp_bad = 1'b1;
      else begin
        m_active = 1'b1; m_cap = (id == 8'd1); m_seg = seg; m_idx = 0;
        m_miss = (seg >= NS) || (!m_cap && !m_valid[seg]);
        if (m_cap) begin
          exp_sa = addr; exp_sa_known = 1'b1;
          if (seg < NS) begin
            m_valid[seg] = 1'b0; m_start[seg] = addr; m_start_known[seg] = 1'b1;
          end
        end else begin
          exp_sa_known = (seg < NS) && m_start_known[seg];
          if (exp_sa_known) exp_sa = m_start[seg];
        end
      end
    end
    if (req && m_active) begin
      if (m_cap) begin
        exp_d = d;
        if (!m_miss) m_mem[m_seg][m_idx] = d;
      end else begin
        exp_d = m_miss ? 8'h00 : m_mem[m_seg][m_idx];
      end
      q.push_back('{cyc + 2, exp_d});
      m_idx++;
      if (m_idx == PB) begin
        m_active = 1'b0;
        if (m_cap && !m_miss) m_valid[m_seg] = 1'b1;
      end
    end
    tick();
    frame_start = 1'b0;
    byte_req    = 1'b0;
    n_checks++;
    if (bad_id !== exp_bad) begin
      n_fail++; $display("FAIL bad_id cyc=%0d: got %b, expected %b", cyc, bad_id, exp_bad);
    end
    n_checks++;
    if (busy !== m_active) begin
      n_fail++; $display("FAIL busy cyc=%0d: got %b, expected %b", cyc, busy, m_active);
    end
    if (m_active) begin
      n_checks++;
      if (replay_miss !== m_miss) begin
        n_fail++; $display("FAIL replay_miss cyc=%0d: got %b, expected %b", cyc, replay_miss, m_miss);
      end
    end
    if (exp_sa_known) begin
      n_checks++;
      if (startaddr !== exp_sa) begin
        n_fail++; $display("FAIL startaddr cyc=%0d: got %h, expected %h", cyc, startaddr, exp_sa);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 0, 24'd0, 1'b0, 8'd0);
  endtask

  // Frame with requests spaced `gap` idle cycles apart; first request coincides with frame_start
  task automatic frame(input logic [7:0] id, input int seg, input logic [23:0] addr,
                       input int nreq, input int gap, input logic [7:0] base);
    step(1'b1, id, seg, addr, 1'b1, base);
    for (int k = 1; k < nreq; k++) begin
      idle(gap);
      step(1'b0, 8'd0, 0, 24'd0, 1'b1, 8'(base + k));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; frame_start = 1'b0; byte_req = 1'b0;
    #2;
    n_checks++;
    if ({dout, dout_valid, startaddr, replay_miss, bad_id, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got dout=%h v=%b sa=%h miss=%b bad=%b busy=%b, expected all 0",
               dout, dout_valid, startaddr, replay_miss, bad_id, busy);
    end
    q.delete();
    m_active = 1'b0;
    for (int i = 0; i < NS; i++) begin m_valid[i] = 1'b0; m_start_known[i] = 1'b0; end
    exp_sa = '0; exp_sa_known = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    tick();
    do_reset();
    mon_en = 1'b1;
    idle(2);
  endtask

  task automatic test_capture();
    frame(8'd1, 1, 24'h000123, 4, 1, 8'hA1);
    idle(4);
  endtask

  task automatic test_replay();
    frame(8'd2, 1, 24'h0, 4, 0, 8'h00);
    idle(3);
    frame(8'd3, 1, 24'h0, 4, 2, 8'h00);
    idle(4);
  endtask

  task automatic test_replay_miss();
    frame(8'd2, 0, 24'h0, 4, 1, 8'h00);
    idle(3);
    frame(8'd3, 5, 24'h0, 4, 0, 8'h00);
    idle(3);
    frame(8'd1, 5, 24'h00BEEF, 4, 0, 8'h50);
    idle(4);
  endtask

  task automatic test_bad_id();
    step(1'b1, 8'd4, 1, 24'h0, 1'b0, 8'h0);
    for (int k = 0; k < 3; k++) step(1'b0, 8'd0, 0, 24'd0, 1'b1, 8'h11);
    step(1'b1, 8'd0, 0, 24'h0, 1'b1, 8'h0);
    for (int k = 0; k < 3; k++) step(1'b0, 8'd0, 0, 24'd0, 1'b1, 8'h22);
    idle(3);
  endtask

  task automatic test_abort();
    frame(8'd1, 0, 24'h000456, 2, 0, 8'hC0);
    frame(8'd2, 1, 24'h0, 4, 0, 8'h00);
    idle(3);
    frame(8'd2, 0, 24'h0, 4, 0, 8'h00);
    idle(3);
    frame(8'd1, 0, 24'h000789, 2, 1, 8'hD0);
    do_reset();
    frame(8'd3, 0, 24'h0, 4, 0, 8'h00);
    idle(4);
  endtask

  task automatic test_back_to_back();
    frame(8'd1, 1, 24'h000ABC, 5, 0, 8'($urandom));
    idle(3);
    frame(8'd2, 1, 24'h0, 5, 0, 8'h00);
    idle(4);
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      step(1'b1, 8'($urandom_range(0, 4)), int'($urandom_range(0, 2)), 24'($urandom),
           1'($urandom_range(0, 1)), 8'($urandom));
      for (int k = 0; k < int'($urandom_range(1, 10)); k++)
        step(1'b0, 8'd0, 0, 24'd0, $urandom_range(0, 2) != 0, 8'($urandom));
    end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_capture();
    test_replay();
    test_replay_miss();
    test_bad_id();
    test_abort();
    test_back_to_back();
    test_random();
    n_checks++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL drain: got %0d outputs outstanding, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
